// File: rtl/video_timing_pkg.sv
// Shared raster geometry defaults and types for the video timing and stream path.
package video_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam bit          DEF_SYNC_POL  = 1'b1;
    localparam logic [23:0] DEF_BLANK_RGB = 24'h000000;

    typedef enum logic {
        SEEK   = 1'b0,
        LOCKED = 1'b1
    } stream_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/video_timing_counter.sv
// Free-running x/y raster counters with decoded active, sync and frame-start flags.
module video_timing_counter
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic pixclk,
    input  logic rst_n,
    output logic active,
    output logic hsync_region,
    output logic vsync_region,
    output logic frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW = $clog2(H_TOTAL);
    localparam int YW = $clog2(V_TOTAL);

    localparam logic [XW-1:0] X_LAST      = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT_END   = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_SYNC_BEG  = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] X_SYNC_END  = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] Y_LAST      = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_ACT_END   = YW'(V_ACTIVE);
    localparam logic [YW-1:0] Y_SYNC_BEG  = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] Y_SYNC_END  = YW'(V_ACTIVE + V_FP + V_SYNC);

    logic [XW-1:0] x;
    logic [YW-1:0] y;

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + YW'(1);
        end else begin
            x <= x + XW'(1);
        end
    end

    assign active       = (x < X_ACT_END) && (y < Y_ACT_END);
    assign hsync_region = (x >= X_SYNC_BEG) && (x < X_SYNC_END);
    assign vsync_region = (y >= Y_SYNC_BEG) && (y < Y_SYNC_END);
    assign frame_start  = (x == '0) && (y == '0);

endmodule

// File: rtl/video_stream_timing.sv
// Raster timing generator that locks an RGB valid/ready stream to the frame and
// drives registered pixels and syncs toward the TMDS encoders.
module video_stream_timing
    import video_timing_pkg::*;
#(
    parameter int          H_ACTIVE  = DEF_H_ACTIVE,
    parameter int          H_FP      = DEF_H_FP,
    parameter int          H_SYNC    = DEF_H_SYNC,
    parameter int          H_BP      = DEF_H_BP,
    parameter int          V_ACTIVE  = DEF_V_ACTIVE,
    parameter int          V_FP      = DEF_V_FP,
    parameter int          V_SYNC    = DEF_V_SYNC,
    parameter int          V_BP      = DEF_V_BP,
    parameter bit          SYNC_POL  = DEF_SYNC_POL,
    parameter logic [23:0] BLANK_RGB = DEF_BLANK_RGB
) (
    input  logic        pixclk,
    input  logic        rst_n,
    input  logic [23:0] s_data,
    input  logic        s_sof,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        status_clr,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        locked,
    output logic        underflow,
    output logic [7:0]  resync_cnt
);

    logic active;
    logic hsync_region;
    logic vsync_region;
    logic frame_start;

    video_timing_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_counter (
        .pixclk       (pixclk),
        .rst_n        (rst_n),
        .active       (active),
        .hsync_region (hsync_region),
        .vsync_region (vsync_region),
        .frame_start  (frame_start)
    );

    stream_state_t state;
    stream_state_t state_next;
    rgb_t          pix_next;
    logic          underflow_evt;
    logic          resync_evt;

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEEK;
        end else begin
            state <= state_next;
        end
    end

    // LOCKED falls back on a missing beat, an sof off (0,0), or a non-sof beat at (0,0).
    always_comb begin
        state_next = state;
        case (state)
            SEEK:    if (s_valid && s_sof && frame_start) state_next = LOCKED;
            LOCKED:  if (active && (!s_valid || (s_sof != frame_start))) state_next = SEEK;
            default: state_next = SEEK;
        endcase
    end

    always_comb begin
        s_ready       = 1'b0;
        pix_next      = '0;
        underflow_evt = 1'b0;
        case (state)
            SEEK: begin
                s_ready = s_valid && (!s_sof || frame_start);
                if (active) begin
                    pix_next = (s_valid && s_sof && frame_start) ? rgb_t'(s_data)
                                                                 : rgb_t'(BLANK_RGB);
                end
            end
            LOCKED: begin
                if (active) begin
                    if (!s_valid) begin
                        pix_next      = rgb_t'(BLANK_RGB);
                        underflow_evt = 1'b1;
                    end else if (s_sof == frame_start) begin
                        s_ready  = 1'b1;
                        pix_next = rgb_t'(s_data);
                    end else begin
                        // An early sof is held for the next frame; a late frame head is dropped.
                        s_ready  = !s_sof;
                        pix_next = rgb_t'(BLANK_RGB);
                    end
                end
            end
            default: ;
        endcase
        if (!rst_n) s_ready = 1'b0;
    end

    assign resync_evt = (state == LOCKED) && (state_next == SEEK);
    assign locked     = (state == LOCKED);

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            hsync      <= ~SYNC_POL;
            vsync      <= ~SYNC_POL;
            de         <= 1'b0;
            underflow  <= 1'b0;
            resync_cnt <= '0;
        end else begin
            red   <= pix_next.r;
            green <= pix_next.g;
            blue  <= pix_next.b;
            hsync <= hsync_region ? SYNC_POL : ~SYNC_POL;
            vsync <= vsync_region ? SYNC_POL : ~SYNC_POL;
            de    <= active;
            // A new event outranks a simultaneous clear.
            if (underflow_evt) begin
                underflow <= 1'b1;
            end else if (status_clr) begin
                underflow <= 1'b0;
            end
            if (resync_evt) begin
                if (status_clr) begin
                    resync_cnt <= 8'd1;
                end else if (resync_cnt != 8'hFF) begin
                    resync_cnt <= resync_cnt + 8'd1;
                end
            end else if (status_clr) begin
                resync_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_video_stream_timing.sv
// Self-checking bench: a reduced raster instance checked against a position-based
// reference model, plus a full-size instance checked over its first lines.
module tb_video_stream_timing;

    localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
    localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam logic [23:0] BLANK = 24'hA5A5A5;

    logic        pixclk = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] s_data = '0;
    logic        s_sof = 1'b0;
    logic        s_valid = 1'b0;
    logic        status_clr = 1'b0;
    logic        s_ready, hsync, vsync, de, locked, underflow;
    logic [7:0]  red, green, blue, resync_cnt;
    logic        d_s_ready, d_hsync, d_vsync, d_de, d_locked, d_underflow;
    logic [7:0]  d_red, d_green, d_blue, d_resync_cnt;

    video_stream_timing #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1'b1), .BLANK_RGB(BLANK)
    ) dut (
        .pixclk(pixclk), .rst_n(rst_n), .s_data(s_data), .s_sof(s_sof),
        .s_valid(s_valid), .s_ready(s_ready), .status_clr(status_clr),
        .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync),
        .de(de), .locked(locked), .underflow(underflow), .resync_cnt(resync_cnt)
    );

    video_stream_timing dut_def (
        .pixclk(pixclk), .rst_n(rst_n), .s_data(s_data), .s_sof(s_sof),
        .s_valid(s_valid), .s_ready(d_s_ready), .status_clr(status_clr),
        .red(d_red), .green(d_green), .blue(d_blue), .hsync(d_hsync), .vsync(d_vsync),
        .de(d_de), .locked(d_locked), .underflow(d_underflow), .resync_cnt(d_resync_cnt)
    );

    always #20 pixclk = ~pixclk;

    typedef struct { logic sof; logic [23:0] data; } beat_t;
    typedef struct { int x; int y; logic de; logic hs; logic vs; logic [23:0] rgb; } vec_t;

    beat_t src[$];
    vec_t  vecs[13];
    int    cyc, n_pass, n_total, hs_count, de_count, gap_pct, m_rs;
    bit    m_locked, m_uf, gap_now, check_def;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    endtask

    function automatic logic [23:0] fdata(input int id, input int i);
        return 24'(id * 65536 + i);
    endfunction

    task automatic push_frame(input int id, input int len, input bit rnd);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.sof  = (i == 0);
            b.data = rnd ? 24'($urandom) : fdata(id, i);
            src.push_back(b);
        end
    endtask

    task automatic push_garbage(input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.sof  = 1'b0;
            b.data = 24'hEE0000 + 24'(i);
            src.push_back(b);
        end
    endtask

    // One pixel clock: drive the stream head, predict from the raster position, compare.
    task automatic applyStimulus(input bit clr);
        int x, y, c0, dx, dy;
        bit act, fs, v, sof, e_ready, enter, leave, uf_ev, e_hs, e_vs;
        logic [23:0] d, e_pix;
        c0  = cyc;
        x   = c0 % HT;
        y   = (c0 / HT) % VT;
        act = (x < HA) && (y < VA);
        fs  = (x == 0) && (y == 0);
        v   = (src.size() > 0) && !gap_now && (int'($urandom_range(0, 99)) >= gap_pct);
        if (v) begin
            sof = src[0].sof;
            d   = src[0].data;
        end else begin
            sof = 1'($urandom_range(0, 1));
            d   = 24'($urandom);
        end
        s_valid    = v;
        s_sof      = sof;
        s_data     = d;
        status_clr = clr;

        e_ready = 0; enter = 0; leave = 0; uf_ev = 0; e_pix = 24'h0;
        if (!m_locked) begin
            if (v && !sof) e_ready = 1;
            if (v && sof && fs) begin e_ready = 1; enter = 1; end
            if (act) e_pix = enter ? d : BLANK;
        end else if (act) begin
            if (!v) begin uf_ev = 1; leave = 1; e_pix = BLANK; end
            else if (fs && !sof) begin e_ready = 1; leave = 1; e_pix = BLANK; end
            else if (!fs && sof) begin leave = 1; e_pix = BLANK; end
            else begin e_ready = 1; e_pix = d; end
        end
        e_hs = (x >= HA + HFP) && (x < HA + HFP + HS);
        e_vs = (y >= VA + VFP) && (y < VA + VFP + VS);

        #5;
        checkOutput("s_ready", 32'(s_ready), 32'(e_ready));
        if (s_valid && s_ready) hs_count++;
        if (v && e_ready) void'(src.pop_front());
        @(posedge pixclk);
        #1;
        if (enter) m_locked = 1;
        else if (leave) m_locked = 0;
        if (uf_ev) m_uf = 1;
        else if (clr) m_uf = 0;
        if (leave) m_rs = clr ? 1 : ((m_rs < 255) ? m_rs + 1 : 255);
        else if (clr) m_rs = 0;
        cyc++;

        checkOutput("de", 32'(de), 32'(act));
        checkOutput("hsync", 32'(hsync), 32'(e_hs));
        checkOutput("vsync", 32'(vsync), 32'(e_vs));
        checkOutput("rgb", 32'({red, green, blue}), 32'(e_pix));
        checkOutput("locked", 32'(locked), 32'(m_locked));
        checkOutput("underflow", 32'(underflow), 32'(m_uf));
        checkOutput("resync_cnt", 32'(resync_cnt), 32'(m_rs));
        if (de) de_count++;
        if (check_def) begin
            dx = c0 % 800;
            dy = (c0 / 800) % 525;
            checkOutput("def_de", 32'(d_de), 32'((dx < 640) && (dy < 480)));
            checkOutput("def_hsync", 32'(d_hsync), 32'((dx >= 656) && (dx < 752)));
            checkOutput("def_vsync", 32'(d_vsync), 32'((dy >= 490) && (dy < 492)));
        end
    endtask

    task automatic advance_to(input int tx, input int ty);
        while ((cyc % HT) != tx || ((cyc / HT) % VT) != ty) applyStimulus(1'b0);
    endtask

    task automatic model_reset();
        cyc = 0; m_locked = 0; m_uf = 0; m_rs = 0;
    endtask

    initial begin
        vecs[0]  = '{0, 0, 1'b1, 1'b0, 1'b0, BLANK};
        vecs[1]  = '{7, 0, 1'b1, 1'b0, 1'b0, BLANK};
        vecs[2]  = '{8, 0, 1'b0, 1'b0, 1'b0, 24'h0};
        vecs[3]  = '{9, 0, 1'b0, 1'b0, 1'b0, 24'h0};
        vecs[4]  = '{10, 0, 1'b0, 1'b1, 1'b0, 24'h0};
        vecs[5]  = '{12, 0, 1'b0, 1'b1, 1'b0, 24'h0};
        vecs[6]  = '{13, 0, 1'b0, 1'b0, 1'b0, 24'h0};
        vecs[7]  = '{7, 5, 1'b1, 1'b0, 1'b0, BLANK};
        vecs[8]  = '{14, 5, 1'b0, 1'b0, 1'b0, 24'h0};
        vecs[9]  = '{0, 6, 1'b0, 1'b0, 1'b0, 24'h0};
        vecs[10] = '{3, 7, 1'b0, 1'b0, 1'b1, 24'h0};
        vecs[11] = '{11, 8, 1'b0, 1'b1, 1'b1, 24'h0};
        vecs[12] = '{0, 9, 1'b0, 1'b0, 1'b0, 24'h0};
        n_pass = 0; n_total = 0; hs_count = 0; de_count = 0;
        gap_pct = 0; gap_now = 0; check_def = 0;
        model_reset();

        #2 rst_n = 1'b0;
        s_valid = 1'b1;
        s_sof   = 1'b0;
        #3;
        checkOutput("reset_s_ready", 32'(s_ready), 32'(0));
        checkOutput("reset_de", 32'(de), 32'(0));
        checkOutput("reset_rgb", 32'({red, green, blue}), 32'(0));
        checkOutput("reset_hsync", 32'(hsync), 32'(0));
        checkOutput("reset_vsync", 32'(vsync), 32'(0));
        checkOutput("reset_locked", 32'(locked), 32'(0));
        checkOutput("reset_underflow", 32'(underflow), 32'(0));
        checkOutput("reset_resync", 32'(resync_cnt), 32'(0));
        repeat (3) @(posedge pixclk);
        #1 rst_n = 1'b1;
        model_reset();

        // Free run with no source: fixed raster decode points, de per frame.
        check_def = 1;
        for (int i = 0; i < 13; i++) begin
            advance_to(vecs[i].x, vecs[i].y);
            applyStimulus(1'b0);
            checkOutput($sformatf("vec%0d_de", i), 32'(de), 32'(vecs[i].de));
            checkOutput($sformatf("vec%0d_hsync", i), 32'(hsync), 32'(vecs[i].hs));
            checkOutput($sformatf("vec%0d_vsync", i), 32'(vsync), 32'(vecs[i].vs));
            checkOutput($sformatf("vec%0d_rgb", i), 32'({red, green, blue}), 32'(vecs[i].rgb));
        end
        advance_to(0, 0);
        de_count = 0;
        repeat (HT * VT) applyStimulus(1'b0);
        checkOutput("de_per_frame", 32'(de_count), 32'(HA * VA));
        while (cyc < 1700) applyStimulus(1'b0);
        check_def = 0;

        // Continuous source carrying the pixel index.
        push_frame(0, HA * VA, 1'b0);
        push_frame(0, HA * VA, 1'b0);
        advance_to(0, 0);
        hs_count = 0;
        applyStimulus(1'b0);
        checkOutput("cont_first_rgb", 32'({red, green, blue}), 32'(0));
        checkOutput("cont_locked", 32'(locked), 32'(1));
        advance_to(HA - 1, VA - 1);
        applyStimulus(1'b0);
        checkOutput("cont_last_rgb", 32'({red, green, blue}), 32'(HA * VA - 1));
        checkOutput("cont_beats", 32'(hs_count), 32'(HA * VA));
        checkOutput("cont_no_underflow", 32'(underflow), 32'(0));
        advance_to(0, 0);
        applyStimulus(1'b0);
        advance_to(0, 0);
        applyStimulus(1'b0);
        checkOutput("empty_underflow", 32'(underflow), 32'(1));
        checkOutput("empty_resync", 32'(resync_cnt), 32'(1));

        // Garbage ahead of sof, then underflow, early sof and clear-vs-event.
        applyStimulus(1'b1);
        checkOutput("clr_underflow", 32'(underflow), 32'(0));
        checkOutput("clr_resync", 32'(resync_cnt), 32'(0));
        hs_count = 0;
        push_garbage(5);
        push_frame(1, HA * VA, 1'b0);
        push_frame(2, HA * VA, 1'b0);
        push_frame(3, HA * VA, 1'b0);
        push_frame(4, 2 * HA + 4, 1'b0);
        push_frame(5, HA * VA, 1'b0);
        push_frame(6, HA * VA, 1'b0);
        advance_to(0, 0);
        checkOutput("garbage_dropped", 32'(hs_count), 32'(5));
        applyStimulus(1'b0);
        checkOutput("sof_first_pixel", 32'({red, green, blue}), 32'(fdata(1, 0)));
        checkOutput("sof_locked", 32'(locked), 32'(1));

        advance_to(0, 0);
        applyStimulus(1'b0);
        advance_to(3, 4);
        gap_now = 1;
        applyStimulus(1'b0);
        gap_now = 0;
        checkOutput("gap_rgb", 32'({red, green, blue}), 32'(BLANK));
        checkOutput("gap_underflow", 32'(underflow), 32'(1));
        checkOutput("gap_resync", 32'(resync_cnt), 32'(1));
        checkOutput("gap_locked", 32'(locked), 32'(0));
        advance_to(HA - 1, VA - 1);
        applyStimulus(1'b0);
        checkOutput("gap_tail_rgb", 32'({red, green, blue}), 32'(BLANK));
        advance_to(0, 0);
        applyStimulus(1'b0);
        checkOutput("relock_rgb", 32'({red, green, blue}), 32'(fdata(3, 0)));
        checkOutput("relock_locked", 32'(locked), 32'(1));

        advance_to(0, 0);
        applyStimulus(1'b0);
        advance_to(4, 2);
        applyStimulus(1'b1);
        checkOutput("early_sof_rgb", 32'({red, green, blue}), 32'(BLANK));
        checkOutput("early_sof_resync", 32'(resync_cnt), 32'(1));
        checkOutput("early_sof_uf_clr", 32'(underflow), 32'(0));
        checkOutput("early_sof_locked", 32'(locked), 32'(0));
        advance_to(0, 0);
        applyStimulus(1'b0);
        checkOutput("held_sof_rgb", 32'({red, green, blue}), 32'(fdata(5, 0)));
        checkOutput("held_sof_locked", 32'(locked), 32'(1));

        // Asynchronous reset in the middle of an active line.
        advance_to(5, 3);
        applyStimulus(1'b0);
        s_valid = 1'b1;
        s_sof   = 1'b0;
        #4 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_de", 32'(de), 32'(0));
        checkOutput("mid_rst_rgb", 32'({red, green, blue}), 32'(0));
        checkOutput("mid_rst_hsync", 32'(hsync), 32'(0));
        checkOutput("mid_rst_vsync", 32'(vsync), 32'(0));
        checkOutput("mid_rst_locked", 32'(locked), 32'(0));
        checkOutput("mid_rst_resync", 32'(resync_cnt), 32'(0));
        checkOutput("mid_rst_s_ready", 32'(s_ready), 32'(0));
        repeat (2) @(posedge pixclk);
        #1 rst_n = 1'b1;
        model_reset();
        src.delete();
        applyStimulus(1'b0);
        checkOutput("post_rst_de", 32'(de), 32'(1));
        checkOutput("post_rst_rgb", 32'({red, green, blue}), 32'(BLANK));
        repeat (HT * VT) applyStimulus(1'b0);

        // Randomised traffic: gaps, garbage, truncated frames, stray clears.
        gap_pct = 3;
        for (int k = 0; k < 1500; k++) begin
            if (src.size() < 60) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r < 2) push_garbage(int'($urandom_range(1, 3)));
                push_frame(0, (r == 9) ? int'($urandom_range(1, HA * VA - 1)) : HA * VA, 1'b1);
            end
            applyStimulus($urandom_range(0, 99) < 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #(40 * 20000);
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
